// File: rtl/uart_tx_queue.sv
// Transmit byte queue ahead of a UART transmitter: buffers CPU writes in a FIFO
// and releases them one per frame time as a single-cycle write strobe.
module uart_tx_queue #(
    parameter int BaudRate     = 9600,
    parameter int ParityBit    = 0,
    parameter int DataBitsSize = 8,
    parameter int StopBitsSize = 1,
    parameter int BufferSize   = 16,
    parameter int ClockFreqHz  = 10000000,
    parameter int GuardCycles  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DataBitsSize-1:0]       push_data,
    output logic                          full,
    output logic [$clog2(BufferSize):0]   count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          idle,
    output logic                          tx_write,
    output logic [DataBitsSize-1:0]       tx_write_data
);

    localparam int CYCLES_PER_BIT = ClockFreqHz / BaudRate;
    localparam int FRAME_CYCLES   = CYCLES_PER_BIT * (1 + DataBitsSize + ParityBit + StopBitsSize);
    localparam int SPACING        = FRAME_CYCLES + GuardCycles;
    localparam int PTR_W          = $clog2(BufferSize);
    localparam int CNT_W          = PTR_W + 1;
    localparam int TMR_W          = $clog2(SPACING);

    generate
        if (SPACING < 2) begin : g_bad_spacing
            $error("uart_tx_queue: frame spacing must be at least 2 cycles");
        end
        if ((BufferSize < 2) || ((BufferSize & (BufferSize - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_queue: BufferSize must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [CNT_W-1:0]         count_r;
    logic [TMR_W-1:0]         timer_r;
    logic [TMR_W-1:0]         timer_next_s;
    logic                     tx_write_r;
    logic                     tx_write_next_s;
    logic [DataBitsSize-1:0]  tx_data_r;
    logic [DataBitsSize-1:0]  tx_data_next_s;
    logic                     overflow_r;
    logic [DataBitsSize-1:0]  mem_r [BufferSize];
    logic                     full_s;
    logic                     push_ok_s;
    logic                     pop_s;

    // Full is judged on the registered count, so a pop in the same cycle never frees a slot early.
    assign full_s    = (count_r == CNT_W'(BufferSize));
    assign push_ok_s = push && !full_s;

    assign full          = full_s;
    assign count         = count_r;
    assign overflow      = overflow_r;
    assign idle          = (state_r == ST_IDLE) && (count_r == {CNT_W{1'b0}});
    assign tx_write      = tx_write_r;
    assign tx_write_data = tx_data_r;

    // Next-state and strobe decode: issue a byte from IDLE, then time out one frame in WAIT.
    always_comb begin
        state_next_s    = state_r;
        timer_next_s    = timer_r;
        tx_write_next_s = 1'b0;
        tx_data_next_s  = tx_data_r;
        pop_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    tx_write_next_s = 1'b1;
                    tx_data_next_s  = mem_r[rd_ptr_r];
                    pop_s           = 1'b1;
                    timer_next_s    = TMR_W'(SPACING - 2);
                    state_next_s    = ST_WAIT;
                end else begin
                    state_next_s    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (timer_r != {TMR_W{1'b0}}) begin
                    timer_next_s = timer_r - TMR_W'(1);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM, pacing timer and transmitter-facing output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            timer_r    <= {TMR_W{1'b0}};
            tx_write_r <= 1'b0;
            tx_data_r  <= {DataBitsSize{1'b0}};
        end else begin
            state_r    <= state_next_s;
            timer_r    <= timer_next_s;
            tx_write_r <= tx_write_next_s;
            tx_data_r  <= tx_data_next_s;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (push && full_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Byte storage; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue at 10 MHz / 1 Mbaud (102-cycle strobe spacing).
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push;
    logic [7:0] push_data;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clr;
    logic       idle;
    logic       tx_write;
    logic [7:0] tx_write_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] got_q[$];
    int         stamp_q[$];

    uart_tx_queue #(
        .BaudRate(1000000),
        .ClockFreqHz(10000000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .push_data(push_data),
        .full(full),
        .count(count),
        .overflow(overflow),
        .overflow_clr(overflow_clr),
        .idle(idle),
        .tx_write(tx_write),
        .tx_write_data(tx_write_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the cycle number of the edge that launched it.
    always @(negedge clk) begin
        if (tx_write === 1'b1) begin
            got_q.push_back(tx_write_data);
            stamp_q.push_back(cyc);
        end
    end

    typedef struct {
        logic       push;
        logic [7:0] data;
        logic       clr;
        logic [4:0] e_count;
        logic       e_full;
        logic       e_ovf;
        logic       e_txw;
        logic [7:0] e_txd;
        logic       e_idle;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (got_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        chk("strobe_count", 32'(got_q.size()), 32'(target));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (idle !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(idle), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_write"}, 32'(tx_write), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_write_data), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        int base;
        rst_n        = 1'b0;
        push         = 1'b0;
        push_data    = 8'h00;
        overflow_clr = 1'b0;

        // Reset state
        repeat (3) tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Single byte: strobe launched on the second edge, idle back after the frame
        push = 1'b1; push_data = 8'h41;
        tick();
        push = 1'b0;
        chk("single_count_after_push", 32'(count), 32'd1);
        chk("single_no_early_strobe", 32'(tx_write), 32'd0);
        tick();
        chk("single_strobe", 32'(tx_write), 32'd1);
        chk("single_data", 32'(tx_write_data), 32'h41);
        chk("single_count_after_pop", 32'(count), 32'd0);
        chk("single_idle_in_frame", 32'(idle), 32'd0);
        tick();
        chk("single_strobe_one_cycle", 32'(tx_write), 32'd0);
        repeat (99) tick();
        chk("single_idle_still_low", 32'(idle), 32'd0);
        tick();
        chk("single_idle_returns", 32'(idle), 32'd1);
        chk("single_data_held", 32'(tx_write_data), 32'h41);

        // Three consecutive pushes, table driven
        tbl[0] = '{1'b1, 8'h10, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
        tbl[1] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0};
        tbl[2] = '{1'b1, 8'h12, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0};
        base = got_q.size();
        for (int i = 0; i < 6; i++) begin
            push = tbl[i].push; push_data = tbl[i].data; overflow_clr = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].e_full));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d_tx_write", i), 32'(tx_write), 32'(tbl[i].e_txw));
            chk($sformatf("vec%0d_tx_data", i), 32'(tx_write_data), 32'(tbl[i].e_txd));
            chk($sformatf("vec%0d_idle", i), 32'(idle), 32'(tbl[i].e_idle));
        end
        push = 1'b0; overflow_clr = 1'b0;
        wait_strobes(base + 3, 400);
        if (got_q.size() >= base + 3) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("three_data%0d", k), 32'(got_q[base + k]), 32'(8'h10 + k));
            chk("three_spacing1", 32'(stamp_q[base + 1] - stamp_q[base]), 32'd102);
            chk("three_spacing2", 32'(stamp_q[base + 2] - stamp_q[base + 1]), 32'd102);
        end
        wait_idle(300);

        // Overflow burst: 20 pushes, bytes 17..19 find the queue full
        base = got_q.size();
        for (int i = 0; i < 20; i++) begin
            push = 1'b1; push_data = 8'hA0 + 8'(i);
            tick();
        end
        push = 1'b0;
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_count", 32'(count), 32'd16);
        chk("burst_overflow", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);
        push = 1'b1; push_data = 8'hEE; overflow_clr = 1'b1;
        tick();
        push = 1'b0; overflow_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_drop_count", 32'(count), 32'd16);
        wait_strobes(base + 17, 17 * 102 + 300);
        wait_idle(300);
        chk("burst_total_sent", 32'(got_q.size() - base), 32'd17);
        if (got_q.size() >= base + 17)
            for (int k = 0; k < 17; k++)
                chk($sformatf("burst_data%0d", k), 32'(got_q[base + k]), 32'(8'hA0 + k));
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("burst_ovf_cleared", 32'(overflow), 32'd0);

        // Fill and drain three times to wrap the pointers
        base = got_q.size();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                push = 1'b1; push_data = 8'(r * 16 + i);
                tick();
            end
            push = 1'b0;
            wait_idle(16 * 102 + 300);
            chk($sformatf("round%0d_count", r), 32'(count), 32'd0);
        end
        chk("wrap_total_sent", 32'(got_q.size() - base), 32'd48);
        if (got_q.size() >= base + 48)
            for (int k = 0; k < 48; k++)
                if (got_q[base + k] !== 8'(k))
                    chk($sformatf("wrap_data%0d", k), 32'(got_q[base + k]), 32'(k));
        chk("wrap_no_overflow", 32'(overflow), 32'd0);

        // Reset in the middle of a frame with five bytes still queued
        base = got_q.size();
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; push_data = 8'hC0 + 8'(i);
            tick();
        end
        push = 1'b0;
        chk("midreset_queued", 32'(count), 32'd5);
        repeat (25) tick();
        rst_n = 1'b0;
        #2;
        chk_reset_vals("midreset");
        tick();
        rst_n = 1'b1;
        repeat (300) tick();
        chk("midreset_no_strobe", 32'(got_q.size() - base), 32'd1);
        push = 1'b1; push_data = 8'h5A;
        tick();
        push = 1'b0;
        wait_strobes(base + 2, 50);
        if (got_q.size() >= base + 2)
            chk("after_reset_data", 32'(got_q[base + 1]), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
